tx_lane_scheduler: RTL and testbench

TX_LANE_SCHEDULER -- requirements
Module: tx_lane_scheduler

---
 rtl/tx_lane_scheduler.sv | 145 ++++++++++++++
 tb/tb_tx_lane_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_lane_scheduler.sv
// Two-requester byte scheduler for a TX lane: COM sync preamble,
// then burst-limited round-robin arbitration into a registered byte stream.
module tx_lane_scheduler #(
  parameter int SYNC_COUNT = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic        resync,
  input  logic [7:0]  req0_data,
  input  logic [7:0]  req1_data,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        synced,
  output logic [15:0] byte_count
);

  localparam logic [7:0] COM       = 8'hBC;
  localparam logic [7:0] SYNC_LAST = 8'(SYNC_COUNT - 1);
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    ARB
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] sync_cnt, sync_cnt_nxt;
  logic [7:0] burst_cnt, burst_cnt_nxt;
  logic       locked, locked_nxt;
  logic       owner, owner_nxt;
  logic       last_served, last_served_nxt;
  logic       xfer;
  logic       win;
  logic [7:0] xfer_data;

  // Grant: locked owner only, else single valid, else tie to non-last.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset && state == ARB) begin
      if (locked) begin
        if (owner) req1_ready = req1_valid;
        else       req0_ready = req0_valid;
      end else if (req0_valid && req1_valid) begin
        req0_ready = last_served;
        req1_ready = ~last_served;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign xfer      = req0_ready | req1_ready;
  assign win       = req1_ready;
  assign xfer_data = win ? req1_data : req0_data;

  always_comb begin
    state_nxt       = state;
    sync_cnt_nxt    = sync_cnt;
    burst_cnt_nxt   = burst_cnt;
    locked_nxt      = locked;
    owner_nxt       = owner;
    last_served_nxt = last_served;

    if (state == ARB) begin
      if (xfer) begin
        if (locked) begin
          burst_cnt_nxt = burst_cnt + 8'd1;
        end else begin
          locked_nxt    = 1'b1;
          owner_nxt     = win;
          burst_cnt_nxt = 8'd1;
        end
        if (burst_cnt_nxt == BURST_MAX) begin
          locked_nxt      = 1'b0;
          last_served_nxt = owner_nxt;
          burst_cnt_nxt   = 8'd0;
        end
      end else if (locked) begin
        locked_nxt      = 1'b0;
        last_served_nxt = owner;
        burst_cnt_nxt   = 8'd0;
      end
    end

    unique case (state)
      IDLE: begin
        state_nxt    = SYNC;
        sync_cnt_nxt = 8'd0;
      end
      SYNC: begin
        if (sync_cnt == SYNC_LAST) begin
          state_nxt    = ARB;
          sync_cnt_nxt = 8'd0;
        end else begin
          sync_cnt_nxt = sync_cnt + 8'd1;
        end
      end
      ARB: ;
      default: state_nxt = IDLE;
    endcase

    // Resync keeps last_served so fairness survives the re-sync.
    if (resync && state != IDLE) begin
      state_nxt     = SYNC;
      sync_cnt_nxt  = 8'd0;
      locked_nxt    = 1'b0;
      burst_cnt_nxt = 8'd0;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state       <= IDLE;
      sync_cnt    <= 8'd0;
      burst_cnt   <= 8'd0;
      locked      <= 1'b0;
      owner       <= 1'b0;
      last_served <= 1'b1;
      data_out    <= COM;
      valid_out   <= 1'b0;
      synced      <= 1'b0;
      byte_count  <= 16'd0;
    end else begin
      state       <= state_nxt;
      sync_cnt    <= sync_cnt_nxt;
      burst_cnt   <= burst_cnt_nxt;
      locked      <= locked_nxt;
      owner       <= owner_nxt;
      last_served <= last_served_nxt;
      data_out    <= xfer ? xfer_data : COM;
      valid_out   <= xfer;
      synced      <= (state == ARB);
      byte_count  <= byte_count + 16'(xfer);
    end
  end

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// Scoreboard bench for tx_lane_scheduler: directed scenarios plus
// random traffic against a per-cycle behavioural model.
module tb_tx_lane_scheduler;

  localparam int SC = 4;
  localparam int MB = 8;

  logic        clk_4f = 1'b0;
  logic        reset  = 1'b1;
  logic        resync = 1'b0;
  logic [7:0]  req0_data = 8'd0;
  logic [7:0]  req1_data = 8'd0;
  logic        req0_valid = 1'b0;
  logic        req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [7:0]  data_out;
  logic        valid_out, synced;
  logic [15:0] byte_count;

  always #5 clk_4f = ~clk_4f;

  tx_lane_scheduler #(.SYNC_COUNT(SC), .MAX_BURST(MB)) dut (
    .clk_4f(clk_4f), .reset(reset), .resync(resync),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .data_out(data_out), .valid_out(valid_out),
    .synced(synced), .byte_count(byte_count)
  );

  typedef struct packed {
    logic        v;
    logic [7:0]  d;
    logic        s;
    logic [15:0] bc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 sync, 2 arbitrating.
  int m_phase = 0;
  int m_left = 0;
  bit m_locked = 0;
  int m_owner = 0;
  int m_run = 0;
  int m_last = 1;
  int m_bytes = 0;

  task automatic step(input bit rst, input bit rs, input bit v0, input bit v1);
    logic [7:0] d0, d1;
    bit r0, r1;
    int w;
    exp_t e;
    @(negedge clk_4f);
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    reset = rst; resync = rs;
    req0_valid = v0; req1_valid = v1;
    req0_data = d0; req1_data = d1;
    #1;
    r0 = 0; r1 = 0;
    if (!rst && m_phase == 2) begin
      if (m_locked) begin
        if (m_owner == 0) r0 = v0;
        else r1 = v1;
      end else if (v0 && v1) begin
        if (m_last == 1) r0 = 1;
        else r1 = 1;
      end else begin
        r0 = v0; r1 = v1;
      end
    end
    checks++;
    if (req0_ready !== r0 || req1_ready !== r1) begin
      errors++;
      $display("FAIL ready: got %b%b expected %b%b", req0_ready, req1_ready, r0, r1);
    end
    if (rst) begin
      e = '{v: 1'b0, d: 8'hBC, s: 1'b0, bc: 16'd0};
      m_phase = 0; m_left = 0; m_locked = 0; m_run = 0; m_last = 1; m_bytes = 0;
    end else begin
      w = r1 ? 1 : 0;
      if (r0 || r1) m_bytes = (m_bytes + 1) % 65536;
      e.v = r0 | r1;
      e.d = r1 ? d1 : (r0 ? d0 : 8'hBC);
      e.s = (m_phase == 2);
      e.bc = 16'(m_bytes);
      if (m_phase == 2) begin
        if (r0 || r1) begin
          if (!m_locked) begin
            m_locked = 1; m_owner = w; m_run = 1;
          end else m_run++;
          if (m_run == MB) begin
            m_locked = 0; m_last = m_owner;
          end
        end else if (m_locked) begin
          m_locked = 0; m_last = m_owner;
        end
      end
      if (m_phase == 0) begin
        m_phase = 1; m_left = SC;
      end else if (rs) begin
        m_phase = 1; m_left = SC; m_locked = 0;
      end else if (m_phase == 1) begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
    end
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk_4f);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (valid_out !== e.v || data_out !== e.d || synced !== e.s || byte_count !== e.bc) begin
          errors++;
          $display("FAIL out: got v=%b d=%h s=%b bc=%h expected v=%b d=%h s=%b bc=%h",
                   valid_out, data_out, synced, byte_count, e.v, e.d, e.s, e.bc);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask

  task automatic wait_sync();
    int n = 0;
    while (m_phase != 2 && n < 300) begin
      step(0, 0, 0, 0);
      n++;
    end
    if (m_phase != 2) begin
      errors++;
      $display("FAIL wait_sync: got timeout expected arbitration");
    end
  endtask

  initial begin
    int first;
    bit rr, rs, v0, v1;

    // Reset state and sync timing
    do_reset();
    @(posedge clk_4f); #2;
    chk("reset_valid", int'(valid_out), 0);
    chk("reset_data", int'(data_out), 8'hBC);
    chk("reset_count", int'(byte_count), 0);
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 0, 0);
      @(posedge clk_4f); #2;
      if (first == 0 && synced === 1'b1) first = k;
    end
    chk("synced_edge", first, 6);

    // Both requesters continuously valid
    do_reset();
    wait_sync();
    for (int k = 0; k < 32; k++) step(0, 0, 1, 1);
    @(posedge clk_4f); #2;
    chk("count_32", int'(byte_count), 32);

    // req0 short burst then drop, req1 waiting
    for (int k = 0; k < 3; k++) step(0, 0, 1, 1);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1);

    // Lone req1 across burst boundaries
    do_reset();
    wait_sync();
    for (int k = 0; k < 20; k++) step(0, 0, 0, 1);
    @(posedge clk_4f); #2;
    chk("count_20", int'(byte_count), 20);

    // Resync mid-burst
    for (int k = 0; k < 3; k++) step(0, 0, 1, 1);
    step(0, 1, 1, 1);
    for (int k = 0; k < 12; k++) step(0, 0, 1, 1);
    step(0, 1, 1, 1);
    step(0, 1, 1, 1);
    for (int k = 0; k < 8; k++) step(0, 0, 1, 1);

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      rr = ($urandom_range(0, 299) == 0);
      rs = ($urandom_range(0, 59) == 0);
      v0 = ($urandom_range(0, 9) < 7);
      v1 = ($urandom_range(0, 9) < 6);
      step(rr, rs, v0, v1);
    end

    // byte_count wrap
    do_reset();
    wait_sync();
    for (int k = 0; k < 65537; k++) step(0, 0, 0, 1);
    @(posedge clk_4f); #2;
    chk("count_wrap", int'(byte_count), 1);

    @(posedge clk_4f); #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
